// File: rtl/eth_header_tx_if.sv
// Payload-in / frame-out stream bundle for the Ethernet II header transmitter.
// The master side is the transmitter; the slave side is its upstream/downstream peer.
interface eth_header_tx_if #(
    parameter int N = 2
) ();
    logic [N-1:0] axiid;
    logic         axiiv;
    logic         axiir;
    logic [N-1:0] axiod;
    logic         axiov;

    modport master (
        input  axiid,
        input  axiiv,
        output axiir,
        output axiod,
        output axiov
    );

    modport slave (
        output axiid,
        output axiiv,
        input  axiir,
        input  axiod,
        input  axiov
    );
endinterface

// File: rtl/eth_header_tx.sv
// Ethernet II header serializer: emits dst MAC, src MAC and EtherType MSB-first as
// N-bit chunks, then forwards a contiguous upstream payload until valid drops.
module eth_header_tx #(
    parameter int N = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [47:0]     dst_mac,
    input  logic [47:0]     src_mac,
    input  logic            etype_sel,
    eth_header_tx_if.master bus,
    output logic            busy,
    output logic            done
);
    localparam int HDR_CHUNKS  = 112 / N;
    localparam int MAC_CHUNKS  = 48 / N;
    localparam int TYPE_CHUNKS = 16 / N;
    localparam int CNT_W       = $clog2(HDR_CHUNKS);

    localparam logic [CNT_W-1:0] MAC_LAST  = CNT_W'(MAC_CHUNKS - 1);
    localparam logic [CNT_W-1:0] TYPE_LAST = CNT_W'(TYPE_CHUNKS - 1);
    localparam logic [15:0]      ETYPE_IPV4 = 16'h0800;
    localparam logic [15:0]      ETYPE_ARP  = 16'h0806;

    typedef enum logic [2:0] {IDLE, DST, SRC, ETYPE, PAYLOAD} state_t;

    state_t           state;
    state_t           next_field;
    logic             field_end;
    logic [CNT_W-1:0] cnt;
    logic [111:0]     sh;
    logic [N-1:0]     chunk;
    logic             valid;

    assign bus.axiod = chunk;
    assign bus.axiov = valid;
    assign bus.axiir = (state == PAYLOAD);
    assign busy      = (state != IDLE);

    // Field boundary detection; the chunk counter restarts at every field.
    always_comb begin
        field_end  = 1'b0;
        next_field = state;
        case (state)
            DST: begin
                field_end  = (cnt == MAC_LAST);
                next_field = SRC;
            end
            SRC: begin
                field_end  = (cnt == MAC_LAST);
                next_field = ETYPE;
            end
            ETYPE: begin
                field_end  = (cnt == TYPE_LAST);
                next_field = PAYLOAD;
            end
            default: begin
                field_end  = 1'b0;
                next_field = state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            chunk <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    chunk <= '0;
                    valid <= 1'b0;
                    if (start) begin
                        sh    <= {dst_mac, src_mac, etype_sel ? ETYPE_ARP : ETYPE_IPV4};
                        cnt   <= '0;
                        state <= DST;
                    end
                end
                DST, SRC, ETYPE: begin
                    chunk <= sh[111 -: N];
                    valid <= 1'b1;
                    sh    <= {sh[111-N:0], {N{1'b0}}};
                    if (field_end) begin
                        cnt   <= '0;
                        state <= next_field;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PAYLOAD: begin
                    // The first gap in upstream valid closes the frame.
                    if (bus.axiiv) begin
                        chunk <= bus.axiid;
                        valid <= 1'b1;
                    end else begin
                        chunk <= '0;
                        valid <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_header_tx.sv
// Directed bench for eth_header_tx at N=2 and N=8 with an expected-chunk scoreboard
// per instance; monitors pop and compare every valid output chunk.
module tb_eth_header_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic        etype_sel = 1'b0;
    logic        busy, done, busy8, done8;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp2_q[$];
    logic [7:0] exp8_q[$];
    int done2_cnt = 0, ir2_cnt = 0, run2 = 0, last_run2 = 0;
    int done8_cnt = 0, ir8_cnt = 0, run8 = 0, last_run8 = 0;

    eth_header_tx_if #(.N(2)) bus2 ();
    eth_header_tx_if #(.N(8)) bus8 ();

    eth_header_tx #(.N(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .dst_mac(dst_mac), .src_mac(src_mac),
        .etype_sel(etype_sel), .bus(bus2.master), .busy(busy), .done(done)
    );

    eth_header_tx #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dst_mac(dst_mac), .src_mac(src_mac),
        .etype_sel(etype_sel), .bus(bus8.master), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] e2;
        if (bus2.axiov) begin
            checks++;
            if (exp2_q.size() == 0) begin
                assert (exp2_q.size() != 0) else begin
                    errors++;
                    $error("FAIL n2_extra_chunk observed=%0d expected=none", bus2.axiod);
                end
            end else begin
                e2 = exp2_q.pop_front();
                assert (bus2.axiod === e2) else begin
                    errors++;
                    $error("FAIL n2_chunk#%0d observed=%0d expected=%0d", run2, bus2.axiod, e2);
                end
            end
            run2++;
        end else if (run2 != 0) begin
            last_run2 = run2;
            run2 = 0;
        end
        if (done) done2_cnt++;
        if (bus2.axiir) ir2_cnt++;
    end

    always @(negedge clk) begin
        logic [7:0] e8;
        if (bus8.axiov) begin
            checks++;
            if (exp8_q.size() == 0) begin
                assert (exp8_q.size() != 0) else begin
                    errors++;
                    $error("FAIL n8_extra_chunk observed=%0h expected=none", bus8.axiod);
                end
            end else begin
                e8 = exp8_q.pop_front();
                assert (bus8.axiod === e8) else begin
                    errors++;
                    $error("FAIL n8_chunk#%0d observed=%0h expected=%0h", run8, bus8.axiod, e8);
                end
            end
            run8++;
        end else if (run8 != 0) begin
            last_run8 = run8;
            run8 = 0;
        end
        if (done8) done8_cnt++;
        if (bus8.axiir) ir8_cnt++;
    end

    // inj_at / abort_at: loop cycle for a stray start or a reset pulse (-1 = none).
    task automatic send2(input logic [47:0] d, input logic [47:0] s, input logic sel,
                         input int plen, input int inj_at, input int abort_at);
        logic [111:0] hdr;
        int d0, ir0, cyc, pidx;
        bit fin, aborted;
        hdr = {d, s, (sel ? 16'h0806 : 16'h0800)};
        for (int k = 0; k < 56; k++) exp2_q.push_back(hdr[111-2*k -: 2]);
        for (int k = 0; k < plen; k++) exp2_q.push_back(2'((k + 1) % 4));
        d0 = done2_cnt;
        ir0 = ir2_cnt;
        @(negedge clk);
        dst_mac = d; src_mac = s; etype_sel = sel; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dst_mac = 48'h5A5A_5A5A_5A5A; src_mac = 48'hA5A5_A5A5_A5A5; etype_sel = ~sel;
        cyc = 0; pidx = 0; fin = 0; aborted = 0;
        while (!fin && cyc < 400) begin
            start = (cyc == inj_at);
            if (cyc == inj_at) dst_mac = 48'h1234_5678_9ABC;
            if (cyc == 1) chk("busy_in_frame", 64'(busy), 64'd1);
            if (bus2.axiir && pidx < plen) begin
                bus2.axiid = 2'((pidx + 1) % 4);
                bus2.axiiv = 1'b1;
                pidx++;
            end else begin
                bus2.axiid = '0;
                bus2.axiiv = 1'b0;
            end
            if (cyc == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_axiov", 64'(bus2.axiov), 64'd0);
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_axiir", 64'(bus2.axiir), 64'd0);
                exp2_q.delete();
                #1 rst = 1'b1;
                fin = 1;
                aborted = 1;
            end else begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    fin = 1;
                    chk("done_cycle", 64'(cyc), 64'(57 + plen));
                    chk("busy_at_done", 64'(busy), 64'd0);
                    chk("axiov_at_done", 64'(bus2.axiov), 64'd0);
                end
            end
        end
        start = 1'b0;
        bus2.axiiv = 1'b0;
        chk("frame_finished", 64'(fin), 64'd1);
        if (aborted) begin
            repeat (5) @(negedge clk);
            chk("abort_no_done", 64'(done2_cnt - d0), 64'd0);
            chk("abort_idle", 64'(busy), 64'd0);
        end else begin
            repeat (2) @(negedge clk);
            chk("done_pulses", 64'(done2_cnt - d0), 64'd1);
            chk("valid_run_len", 64'(last_run2), 64'(56 + plen));
            chk("axiir_cycles", 64'(ir2_cnt - ir0), 64'(plen + 1));
            chk("queue_drained", 64'(exp2_q.size()), 64'd0);
            if (inj_at >= 0) begin
                repeat (80) @(negedge clk);
                chk("no_second_frame_done", 64'(done2_cnt - d0), 64'd1);
                chk("no_second_frame_busy", 64'(busy), 64'd0);
            end
        end
    endtask

    task automatic send8(input logic [47:0] d, input logic [47:0] s, input logic sel,
                         input int plen);
        logic [111:0] hdr;
        int d0, ir0, cyc, pidx;
        bit fin;
        hdr = {d, s, (sel ? 16'h0806 : 16'h0800)};
        for (int k = 0; k < 14; k++) exp8_q.push_back(hdr[111-8*k -: 8]);
        for (int k = 0; k < plen; k++) exp8_q.push_back(8'(8'hA0 + k));
        d0 = done8_cnt;
        ir0 = ir8_cnt;
        @(negedge clk);
        dst_mac = d; src_mac = s; etype_sel = sel; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dst_mac = '0; src_mac = '0;
        cyc = 0; pidx = 0; fin = 0;
        while (!fin && cyc < 200) begin
            if (bus8.axiir && pidx < plen) begin
                bus8.axiid = 8'(8'hA0 + pidx);
                bus8.axiiv = 1'b1;
                pidx++;
            end else begin
                bus8.axiid = '0;
                bus8.axiiv = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done8) begin
                fin = 1;
                chk("n8_done_cycle", 64'(cyc), 64'(15 + plen));
                chk("n8_busy_at_done", 64'(busy8), 64'd0);
            end
        end
        bus8.axiiv = 1'b0;
        chk("n8_frame_finished", 64'(fin), 64'd1);
        repeat (2) @(negedge clk);
        chk("n8_done_pulses", 64'(done8_cnt - d0), 64'd1);
        chk("n8_valid_run_len", 64'(last_run8), 64'(14 + plen));
        chk("n8_axiir_cycles", 64'(ir8_cnt - ir0), 64'(plen + 1));
        chk("n8_queue_drained", 64'(exp8_q.size()), 64'd0);
    endtask

    initial begin
        bus2.axiid = '0; bus2.axiiv = 1'b0;
        bus8.axiid = '0; bus8.axiiv = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_axiov", 64'(bus2.axiov), 64'd0);
        chk("rst_axiod", 64'(bus2.axiod), 64'd0);
        chk("rst_axiir", 64'(bus2.axiir), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_n8_axiov", 64'(bus8.axiov), 64'd0);
        chk("rst_n8_busy", 64'(busy8), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // IPv4 broadcast frame, payload 1,2,3,0
        send2(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 1'b0, 4, -1, -1);
        // ARP frame with an irregular MAC pattern
        send2(48'h0A1B_2C3D_4E5F, 48'hDEAD_BEEF_0042, 1'b1, 7, -1, -1);
        // Zero-length payload
        send2(48'h0011_2233_4455, 48'h6677_8899_AABB, 1'b0, 0, -1, -1);
        // Start pulse while busy at header chunk 10
        send2(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 1'b0, 3, 10, -1);
        // Reset during the source MAC field
        send2(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 1'b0, 4, -1, 35);
        // Full frame after the aborted one
        send2(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 1'b1, 5, -1, -1);
        // Byte-wide build: IPv4 frame and a zero-payload ARP frame
        send8(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 1'b0, 3);
        send8(48'h0A1B_2C3D_4E5F, 48'hDEAD_BEEF_0042, 1'b1, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/eth_header_tx.md
Name: eth_header_tx

Overview:
Transmit-side counterpart of the ethertype receive parser. On a start pulse it serializes an Ethernet II header (destination MAC, source MAC, EtherType) onto an N-bit stream. It then passes an upstream payload stream through, gap-free, so that downstream TX logic receives a contiguous frame body. It sits between the IPv4/ARP frame builders and the FCS/preamble stage.

Parameters:
N, 2, stream chunk width in bits; legal values 1, 2, 4, 8. It must divide 16 and 48.
HDR_CHUNKS, 112/N, derived localparam: number of header chunks (56 for N=2).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a frame; honoured only in IDLE
dst_mac  input  48  destination MAC; sampled on accepted start
src_mac  input  48  source MAC; sampled on accepted start
etype_sel  input  1  0 selects IPv4 (16'h0800), 1 selects ARP (16'h0806); sampled on accepted start
axiid  input  N  payload chunk from upstream
axiiv  input  1  payload chunk valid
axiir  output  1  payload ready to upstream (combinational: state==PAYLOAD)
axiod  output  N  output stream chunk (registered)
axiov  output  1  output stream valid (registered)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on the clock edge returning to IDLE

Behaviour:
- Reset (rst low, async): state=IDLE, chunk counter=0, header shift register=0, axiod=0, axiov=0, done=0. busy=0 and axiir=0 follow from state.
- State machine: IDLE -> DST -> SRC -> TYPE -> PAYLOAD -> IDLE.
- IDLE: when start=1 at a clock edge, latch {dst_mac, src_mac, etype} into a 112-bit shift register, counter=0, go to DST. Output stays idle.
- Header emission: each state emits MSB-first N-bit chunks; chunk k of a field is field[W-1-N*k -: N]. Per cycle, axiod=top N bits, axiov=1, shift left by N.
- DST lasts 48/N cycles, SRC lasts 48/N cycles, TYPE lasts 16/N cycles. The counter resets at each field boundary.
- Latency: start sampled at edge t; first header chunk is valid on axiod/axiov after edge t+1; header occupies HDR_CHUNKS consecutive cycles with no gaps.
- TYPE -> PAYLOAD on the edge that registers the last EtherType chunk. axiir is high from the following cycle.
- PAYLOAD, each edge:
  - If axiiv=1: axiod<=axiid, axiov<=1.
  - If axiiv=0: axiov<=0, axiod<=0, done<=1, state<=IDLE.
  - The first payload chunk appears on the cycle immediately after the last EtherType chunk.
- Zero-length payload: axiiv=0 on the first PAYLOAD cycle ends the frame. axiov falls right after the header.
- The payload stream must be contiguous. The first deasserted axiiv in PAYLOAD terminates the frame; later axiiv pulses are ignored until the next start.
- A start in any state other than IDLE is ignored. Header inputs are not re-sampled.
- A start on the same edge that returns to IDLE is ignored. The earliest next frame is start on the cycle after done.
- Reset asserted mid-frame aborts immediately: axiov=0 asynchronously, no done pulse.
- done is high for exactly one cycle per completed frame.

Test Plan:
- IPv4, N=2: dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, etype_sel=0, payload dibits 1,2,3,0 -> 24 dibits of 3; then src dibits 0,0,0,2,0…0,0,0,0,1; then type dibits 0,0,2,0,0,0,0,0; then 1,2,3,0. axiov is high for 60 contiguous cycles, then done pulses.
- ARP, N=2: etype_sel=1 -> type dibits 0,0,2,0,0,0,1,2. The EtherType round-trips through the receive parser, which reports ARP.
- Zero payload: axiiv=0 throughout -> exactly 56 valid cycles, done on edge 57 after start, axiir high for one cycle.
- Start while busy: second start pulse at header chunk 10 with a different dst_mac -> the frame is unchanged and no second frame follows.
- Reset mid-frame: rst low during SRC -> axiov=0 immediately, busy=0, no done. A new start after release produces a full correct frame.
- N=8 build: same IPv4 frame -> 14 header bytes FF×6, 02,00,00,00,00,01, 08,00, then payload bytes.
